// File: rtl/symbol_serializer_pkg.sv
// Shared definitions for the PSK symbol serializer.
package symbol_serializer_pkg;

    localparam int NBITS_BPSK = 1;
    localparam int NBITS_QPSK = 2;

    function automatic int cnt_width(input int n_max);
        return $clog2(n_max + 1);
    endfunction

endpackage

// File: rtl/symbol_serializer_if.sv
// Word-in / bit-out stream bundle of the symbol serializer.
interface symbol_serializer_if #(
    parameter int M = 8
);

    logic [M-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic         m_bit;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_bit, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_bit, m_valid, m_last
    );

endinterface

// File: rtl/symbol_serializer_skid.sv
// Single-entry word hold buffer with registered ready.
module word_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_pop
);

    logic push;
    logic full_next;

    assign push      = wr_valid && wr_ready;
    assign full_next = push || (rd_valid && !rd_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            wr_ready <= 1'b1;
            rd_data  <= '0;
        end else begin
            rd_valid <= full_next;
            wr_ready <= !full_next;
            if (push) begin
                rd_data <= wr_data;
            end
        end
    end

endmodule

// File: rtl/symbol_serializer.sv
// Parallel-to-serial converter: 1..N_MAX bits per word, one per ce_bit.
module symbol_serializer
    import symbol_serializer_pkg::*;
#(
    parameter int M          = 8,
    parameter int N_MAX      = 8,
    parameter int CNT_W      = cnt_width(N_MAX),
    parameter bit MSB_FIRST  = 1'b0,
    parameter int BYPASS_SEL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce_bit,
    input  logic [CNT_W-1:0]    cfg_nbits,
    input  logic                cfg_bypass,
    symbol_serializer_if.slave  bus,
    output logic                underrun
);

    logic [M-1:0]     hold_data;
    logic             hold_full;
    logic             load;
    logic [N_MAX-1:0] sr;
    logic [N_MAX-1:0] sr_next;
    logic [N_MAX-1:0] load_sr;
    logic [N_MAX-1:0] word_low;
    logic [N_MAX-1:0] mask;
    logic [N_MAX-1:0] load_tmp;
    logic [N_MAX-1:0] next_tmp;
    logic [CNT_W-1:0] bits_left;
    logic [CNT_W-1:0] nbits_eff;
    logic             emitted;
    logic             slot_free;
    logic             ce_go;
    logic             next_bit;
    logic             load_bit;

    word_skid_reg #(.W(M)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (bus.s_data),
        .wr_valid (bus.s_valid),
        .wr_ready (bus.s_ready),
        .rd_data  (hold_data),
        .rd_valid (hold_full),
        .rd_pop   (load)
    );

    assign slot_free = !bus.m_valid || bus.m_ready;
    assign ce_go     = ce_bit && slot_free;
    assign load      = ce_go && (bits_left == '0) && hold_full;

    always_comb begin
        if (cfg_bypass || cfg_nbits == '0) begin
            nbits_eff = CNT_W'(NBITS_BPSK);
        end else if (cfg_nbits > CNT_W'(N_MAX)) begin
            nbits_eff = CNT_W'(N_MAX);
        end else begin
            nbits_eff = cfg_nbits;
        end
    end

    // Word bits above nbits_eff are discarded at load.
    always_comb begin
        mask     = ~({N_MAX{1'b1}} << nbits_eff);
        word_low = hold_data[N_MAX-1:0] & mask;
        load_tmp = word_low >> (nbits_eff - 1'b1);
        load_bit = word_low[0];
        load_sr  = word_low >> 1;
        if (cfg_bypass) begin
            load_bit = hold_data[BYPASS_SEL];
            load_sr  = '0;
        end else if (MSB_FIRST) begin
            load_bit = load_tmp[0];
            load_sr  = word_low;
        end
    end

    // MSB-first keeps the word in place and indexes by bits_left.
    always_comb begin
        next_tmp = sr >> (bits_left - 1'b1);
        next_bit = sr[0];
        sr_next  = sr >> 1;
        if (MSB_FIRST) begin
            next_bit = next_tmp[0];
            sr_next  = sr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= '0;
            bits_left   <= '0;
            emitted     <= 1'b0;
            underrun    <= 1'b0;
            bus.m_bit   <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (ce_go) begin
                if (bits_left != '0) begin
                    bus.m_bit   <= next_bit;
                    bus.m_valid <= 1'b1;
                    bus.m_last  <= (bits_left == CNT_W'(1));
                    bits_left   <= bits_left - 1'b1;
                    sr          <= sr_next;
                    emitted     <= 1'b1;
                end else if (hold_full) begin
                    bus.m_bit   <= load_bit;
                    bus.m_valid <= 1'b1;
                    bus.m_last  <= (nbits_eff == CNT_W'(1));
                    bits_left   <= nbits_eff - 1'b1;
                    sr          <= load_sr;
                    emitted     <= 1'b1;
                end else begin
                    // Only the first empty strobe after a word flags underrun.
                    bus.m_valid <= 1'b0;
                    bus.m_last  <= 1'b0;
                    underrun    <= emitted;
                    emitted     <= 1'b0;
                end
            end else if (bus.m_valid && bus.m_ready) begin
                bus.m_valid <= 1'b0;
                bus.m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_symbol_serializer.sv
// Directed bench: LSB-first and MSB-first serializer instances.
module tb_symbol_serializer;
    import symbol_serializer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce_bit = 1'b0;
    logic       cfg_bypass = 1'b0;
    logic [3:0] cfg_nbits = 4'd0;
    logic       underrun;
    logic       underrun_msb;
    logic [7:0] w;
    int         n_vec = 0;
    int         n_bad = 0;

    symbol_serializer_if #(.M(8)) sif ();
    symbol_serializer_if #(.M(8)) mif ();

    symbol_serializer #(
        .M(8), .N_MAX(8), .CNT_W(4),
        .MSB_FIRST(1'b0), .BYPASS_SEL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce_bit(ce_bit),
        .cfg_nbits(cfg_nbits), .cfg_bypass(cfg_bypass),
        .bus(sif), .underrun(underrun)
    );

    symbol_serializer #(
        .M(8), .N_MAX(8), .CNT_W(4),
        .MSB_FIRST(1'b1), .BYPASS_SEL(1)
    ) dut_msb (
        .clk(clk), .rst_n(rst_n), .ce_bit(ce_bit),
        .cfg_nbits(cfg_nbits), .cfg_bypass(cfg_bypass),
        .bus(mif), .underrun(underrun_msb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ce_pulse();
        ce_bit = 1'b1;
        cyc();
        ce_bit = 1'b0;
    endtask

    task automatic push(input bit msb, input logic [7:0] d);
        int n = 0;
        if (msb) begin
            mif.s_data  = d;
            mif.s_valid = 1'b1;
        end else begin
            sif.s_data  = d;
            sif.s_valid = 1'b1;
        end
        while (!(msb ? mif.s_ready : sif.s_ready) && n < 50) begin
            cyc();
            n++;
        end
        check("push_ready", 32'(n < 50), 32'd1);
        cyc();
        mif.s_valid = 1'b0;
        sif.s_valid = 1'b0;
    endtask

    task automatic emit(input bit msb, input string tag,
                        input logic b, input logic l);
        ce_pulse();
        if (msb) begin
            check({tag, "_v"}, 32'(mif.m_valid), 32'd1);
            check({tag, "_b"}, 32'(mif.m_bit), 32'(b));
            check({tag, "_l"}, 32'(mif.m_last), 32'(l));
        end else begin
            check({tag, "_v"}, 32'(sif.m_valid), 32'd1);
            check({tag, "_b"}, 32'(sif.m_bit), 32'(b));
            check({tag, "_l"}, 32'(sif.m_last), 32'(l));
        end
    endtask

    initial begin
        sif.s_data  = '0;
        sif.s_valid = 1'b0;
        sif.m_ready = 1'b1;
        mif.s_data  = '0;
        mif.s_valid = 1'b0;
        mif.m_ready = 1'b1;
        repeat (3) cyc();
        check("rst_bit", 32'(sif.m_bit), 0);
        check("rst_valid", 32'(sif.m_valid), 0);
        check("rst_last", 32'(sif.m_last), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_ready", 32'(sif.s_ready), 1);
        rst_n = 1'b1;
        cyc();

        // QPSK: A6 -> 0,1 ; 01 -> 1,0
        cfg_nbits = 4'(NBITS_QPSK);
        push(0, 8'hA6);
        emit(0, "q0", 1'b0, 1'b0);
        push(0, 8'h01);
        check("q_drop", 32'(sif.m_valid), 0);
        emit(0, "q1", 1'b1, 1'b1);
        emit(0, "q2", 1'b1, 1'b0);
        emit(0, "q3", 1'b0, 1'b1);
        ce_pulse();
        check("ur_pulse", 32'(underrun), 1);
        check("ur_valid", 32'(sif.m_valid), 0);
        ce_pulse();
        check("ur_once", 32'(underrun), 0);

        // Bypass picks bit 1 regardless of nbits
        cfg_bypass = 1'b1;
        cfg_nbits  = 4'd2;
        push(0, 8'h02);
        emit(0, "byp0", 1'b1, 1'b1);
        push(0, 8'hFD);
        emit(0, "byp1", 1'b0, 1'b1);

        // nbits 0 behaves as 1
        cfg_bypass = 1'b0;
        cfg_nbits  = 4'd0;
        push(0, 8'h03);
        emit(0, "n0", 1'b1, 1'b1);

        // nbits 12 clamps to 8
        cfg_nbits = 4'd12;
        w = 8'h96;
        push(0, w);
        for (int i = 0; i < 8; i++) begin
            emit(0, "n12", w[i], 1'(i == 7));
        end

        // Backpressure mid-word: 05 -> 1,0,1,0 ; 0A -> 0,1,0,1
        cfg_nbits = 4'd4;
        push(0, 8'h05);
        emit(0, "bp0", 1'b1, 1'b0);
        sif.m_ready = 1'b0;
        push(0, 8'h0A);
        check("bp_full", 32'(sif.s_ready), 0);
        repeat (3) emit(0, "bp_stall", 1'b1, 1'b0);
        check("bp_no_ur", 32'(underrun), 0);
        sif.m_ready = 1'b1;
        cyc();
        emit(0, "bp1", 1'b0, 1'b0);
        emit(0, "bp2", 1'b1, 1'b0);
        emit(0, "bp3", 1'b0, 1'b1);
        emit(0, "bp4", 1'b0, 1'b0);
        check("bp_freed", 32'(sif.s_ready), 1);
        emit(0, "bp5", 1'b1, 1'b0);
        emit(0, "bp6", 1'b0, 1'b0);
        emit(0, "bp7", 1'b1, 1'b1);

        // Reset mid-word drops partial and buffered words
        push(0, 8'h0C);
        emit(0, "r0", 1'b0, 1'b0);
        push(0, 8'hFF);
        check("r_full", 32'(sif.s_ready), 0);
        rst_n = 1'b0;
        #2;
        check("r_valid", 32'(sif.m_valid), 0);
        check("r_ready", 32'(sif.s_ready), 1);
        check("r_last", 32'(sif.m_last), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        push(0, 8'h09);
        emit(0, "r1", 1'b1, 1'b0);
        emit(0, "r2", 1'b0, 1'b0);
        emit(0, "r3", 1'b0, 1'b0);
        emit(0, "r4", 1'b1, 1'b1);
        ce_pulse();
        check("r_dropped", 32'(sif.m_valid), 0);

        // MSB first: 0B -> 1,0,1,1 ; 06 -> 0,1,1,0 with no bubble
        cfg_nbits = 4'd4;
        push(1, 8'h0B);
        emit(1, "m0", 1'b1, 1'b0);
        push(1, 8'h06);
        emit(1, "m1", 1'b0, 1'b0);
        emit(1, "m2", 1'b1, 1'b0);
        emit(1, "m3", 1'b1, 1'b1);
        emit(1, "m4", 1'b0, 1'b0);
        emit(1, "m5", 1'b1, 1'b0);
        emit(1, "m6", 1'b1, 1'b0);
        emit(1, "m7", 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
